demo_rect_animator: RTL and testbench
=====================================

# demo_rect_animator

Parametrised multi-rectangle animator for the demoscene VGA top. It takes beam position and sync from `hvsync_generator` and animates NUM_RECTS pulsing rectangles. Each rectangle has its own ping-pong size offset, updated once per frame from a synchronous vsync edge detector, with no vsync-as-clock. Output is a pipelined 6-bit RGB plus delayed syncs, ready for the TinyVGA PMOD mapping in the top level.

## Interface
- NUM_RECTS, 3: number of rectangle channels, legal 1..4.
- OFFS_MAX, 200: upper bound of each channel's size offset; offset width OW = $clog2(OFFS_MAX+1).
- BASE_HW, 20: base half-width in pixels.
- BASE_HH, 20: base half-height in pixels.

- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- pix_x  in  10  beam x from hvsync_generator
- pix_y  in  10  beam y
- video_active  in  1  display_on
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- speed  in  3  offset step per frame; 0 = frozen; sampled on frame_tick
- pause  in  1  1 = hold all offsets
- mode  in  1  0 = priority compose, 1 = OR-blend (only with DEMO_BLEND_EN)
- rgb_out  out  6  {R1,R0,G1,G0,B1,B0}
- hsync_out  out  1  hsync_in delayed to match rgb_out
- vsync_out  out  1  vsync_in delayed to match rgb_out
- frame_tick  out  1  one-cycle pulse per vsync rising edge

## Operation
- Frame edge: vsync_in is registered into vs_d. frame_tick <= vsync_in & ~vs_d.
- Per channel i, there is a 2-state FSM {UP, DOWN} and an offset off[i] (OW bits).
  - Reset values: off[i] = i*OFFS_MAX/4 (integer), state UP.
- On frame_tick with pause=0, using the step s = speed:
  - UP: if off+s >= OFFS_MAX, set off=OFFS_MAX and go to DOWN; else off += s.
  - DOWN: if off <= s, set off=0 and go to UP; else off -= s.
  - Compute the comparisons at OW+1 bits so nothing wraps.
  - s=0: offset and state hold.
- pause=1 or no frame_tick: offsets and states hold. frame_tick still pulses while paused.
- Geometry for channel i:
  - Center (CX[i],CY[i]) comes from the package: (320,240), (160,120), (480,360), (320,120).
  - hw = BASE_HW + off.
  - hh = BASE_HH + (off>>1).
  - Hit when |pix_x−CX| < hw and |pix_y−CY| < hh.
  - Use 11-bit signed differences.
  - Rectangles extending past the screen are clipped only by video_active.
- Compose (stage 2):
  - If video_active is low, the output is 0.
  - Priority mode: the lowest-index hit channel's PALETTE[i] wins.
  - Blend mode: bitwise OR of PALETTE[i] over all hit channels.
  - No hit gives 0.

## Timing
- Pipeline is 2 stages.
  - Stage 1 registers per-channel hit bits plus active/hsync/vsync.
  - Stage 2 registers rgb_out, hsync_out and vsync_out.
- pix_x/pix_y sampled at cycle n appear on rgb_out at n+2. Syncs are delayed exactly 2 cycles.
- frame_tick is high in the cycle after vsync_in first samples high. Offsets change in the cycle after frame_tick.
- A speed change mid-frame takes effect only at the next frame_tick.
- Reset asserted mid-frame:
  - All registers clear immediately (asynchronous): rgb_out=0, hsync_out=0, vsync_out=0, frame_tick=0, vs_d=0.
  - Offsets and states return to their reset values.
- After reset release, if vsync_in is already high, one frame_tick fires on the first clock (vs_d=0).

## Configuration
- DEMO_BLEND_EN defined: the mode input selects priority (0) or OR-blend (1).
- DEMO_BLEND_EN undefined: priority compose only. mode is ignored and tied into an unused-signal sink. No blend logic is synthesised.

## Structure
- Package demo_rect_pkg holds:
  - CX/CY center tables.
  - PALETTE table (ch0 6'b000011 blue, ch1 6'b001100 green, ch2 6'b110000 red, ch3 6'b111111 white).
  - Direction enum {UP, DOWN}.
- Sub-module demo_pingpong_ctr holds one channel's offset plus FSM, with parameters OFFS_MAX and RESET_VAL. It is instantiated NUM_RECTS times in a generate loop.

## Test plan
- Reset with NUM_RECTS=3, OFFS_MAX=200 → rgb_out=0, frame_tick=0, off = {0,50,100}, all states UP.
- vsync_in rises, speed=1 → frame_tick high for exactly 1 cycle; offsets become {1,51,101}; a vsync_in held high for 100 cycles gives no second pulse.
- Force off[0]=198 UP, speed=3, one tick → off=200, DOWN; next tick → 197; then off=2 DOWN, speed=3 → 0, UP.
- off[0]=0, video_active=1, pix=(339,240) → rgb_out=6'b000011 two cycles later; pix=(340,240) → 0; video_active=0 → 0.
- Overlap of ch0 (hit) and ch1 (hit): mode=0 → 6'b000011; mode=1 with DEMO_BLEND_EN → 6'b001111; without the macro, mode=1 → 6'b000011.
- pause=1 or speed=0 across 5 frames → offsets unchanged and 5 frame_tick pulses; assert rst_n low mid-line → outputs 0 in the same cycle.

Source files
------------

// File: rtl/demo_rect_pkg.sv
// Shared tables and types for the pulsing-rectangle animator: channel centers,
// channel colours and the ping-pong direction enum.
package demo_rect_pkg;

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

    localparam int MAX_RECTS = 4;

    // Index 0 is the least significant entry of each packed table.
    localparam logic [MAX_RECTS-1:0][9:0] CX = {10'd320, 10'd480, 10'd160, 10'd320};
    localparam logic [MAX_RECTS-1:0][9:0] CY = {10'd120, 10'd360, 10'd120, 10'd240};
    localparam logic [MAX_RECTS-1:0][5:0] PALETTE = {6'b111111, 6'b110000, 6'b001100, 6'b000011};

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] c);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, c});
        return (d < 0) ? 11'(-d) : 11'(d);
    endfunction

endpackage

// File: rtl/demo_pingpong_ctr.sv
// One channel's size offset, bouncing between 0 and OFFS_MAX by step_i on
// every tick_i.
module demo_pingpong_ctr
    import demo_rect_pkg::*;
#(
    parameter int OFFS_MAX  = 200,
    parameter int RESET_VAL = 0,
    parameter int OW        = $clog2(OFFS_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_i,
    input  logic [2:0]    step_i,
    output logic [OW-1:0] off_o
);

    dir_e          state_q, state_d;
    logic [OW-1:0] off_q, off_d;
    logic [OW:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UP;
            off_q   <= OW'(RESET_VAL);
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
        end
    end

    // Comparisons carry one extra bit so off+step never wraps.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        sum     = {1'b0, off_q} + (OW+1)'(step_i);
        if (tick_i && (step_i != 3'd0)) begin
            case (state_q)
                UP: begin
                    if (sum >= (OW+1)'(OFFS_MAX)) begin
                        off_d   = OW'(OFFS_MAX);
                        state_d = DOWN;
                    end else begin
                        off_d = sum[OW-1:0];
                    end
                end
                DOWN: begin
                    if ({1'b0, off_q} <= (OW+1)'(step_i)) begin
                        off_d   = '0;
                        state_d = UP;
                    end else begin
                        off_d = off_q - OW'(step_i);
                    end
                end
                default: begin
                    state_d = UP;
                end
            endcase
        end
    end

    assign off_o = off_q;

endmodule

// File: rtl/demo_rect_animator.sv
// Multi-rectangle animator: per-frame ping-pong sizes, 2-stage hit/compose pipeline.
// Define DEMO_BLEND_EN to enable the OR-blend compose mode selected by `mode`.
module demo_rect_animator
    import demo_rect_pkg::*;
#(
    parameter int NUM_RECTS = 3,
    parameter int OFFS_MAX  = 200,
    parameter int BASE_HW   = 20,
    parameter int BASE_HH   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_active,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] speed,
    input  logic       pause,
    input  logic       mode,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    localparam int OW = $clog2(OFFS_MAX + 1);

    logic                 vs_d_q;
    logic                 frame_tick_q;
    logic [OW-1:0]        off [NUM_RECTS];
    logic [NUM_RECTS-1:0] hit_d, hit_q;
    logic                 act_q, hs_q, vs_q;
    logic [5:0]           rgb_d, rgb_q;
    logic                 hs2_q, vs2_q;

    // Frame edge detection on the pixel clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vs_d_q       <= vsync_in;
            frame_tick_q <= vsync_in & ~vs_d_q;
        end
    end

    for (genvar ch = 0; ch < NUM_RECTS; ch++) begin : g_ch
        demo_pingpong_ctr #(
            .OFFS_MAX  (OFFS_MAX),
            .RESET_VAL ((ch * OFFS_MAX) / 4),
            .OW        (OW)
        ) u_ctr (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_i (frame_tick_q & ~pause),
            .step_i (speed),
            .off_o  (off[ch])
        );
    end

    always_comb begin
        hit_d = '0;
        for (int ch = 0; ch < NUM_RECTS; ch++) begin
            hit_d[ch] = ({1'b0, abs_diff(pix_x, CX[ch])} < (12'(BASE_HW) + 12'(off[ch])))
                     && ({1'b0, abs_diff(pix_y, CY[ch])} < (12'(BASE_HH) + 12'(off[ch] >> 1)));
        end
    end

    // Stage 1: per-channel hits and aligned control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
            act_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            hit_q <= hit_d;
            act_q <= video_active;
            hs_q  <= hsync_in;
            vs_q  <= vsync_in;
        end
    end

`ifdef DEMO_BLEND_EN
    always_comb begin
        rgb_d = '0;
        if (act_q) begin
            if (mode) begin
                for (int ch = 0; ch < NUM_RECTS; ch++) begin
                    if (hit_q[ch]) rgb_d = rgb_d | PALETTE[ch];
                end
            end else begin
                for (int ch = NUM_RECTS - 1; ch >= 0; ch--) begin
                    if (hit_q[ch]) rgb_d = PALETTE[ch];
                end
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Scanning downward lets the lowest-index hit overwrite the others.
    always_comb begin
        rgb_d = '0;
        if (act_q) begin
            for (int ch = NUM_RECTS - 1; ch >= 0; ch--) begin
                if (hit_q[ch]) rgb_d = PALETTE[ch];
            end
        end
    end
`endif

    // Stage 2: composed colour and delayed syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs_q;
            vs2_q <= vs_q;
        end
    end

    assign rgb_out    = rgb_q;
    assign hsync_out  = hs2_q;
    assign vsync_out  = vs2_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_demo_rect_animator.sv
// Directed self-checking bench for demo_rect_animator (default parameters).
module tb_demo_rect_animator;
    import demo_rect_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x, pix_y;
    logic       video_active, hsync_in, vsync_in, pause, mode;
    logic [2:0] speed;
    logic [5:0] rgb_out;
    logic       hsync_out, vsync_out, frame_tick;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int t0;

    demo_rect_animator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .video_active (video_active),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .speed        (speed),
        .pause        (pause),
        .mode         (mode),
        .rgb_out      (rgb_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync_in = 1'b1;
        cyc();
        cyc();
        vsync_in = 1'b0;
        cyc();
        cyc();
    endtask

    function automatic logic [31:0] off0();
        return 32'(dut.g_ch[0].u_ctr.off_q);
    endfunction

    function automatic logic [31:0] st0();
        return 32'(dut.g_ch[0].u_ctr.state_q);
    endfunction

    initial begin
        rst_n = 1'b0;
        pix_x = '0; pix_y = '0;
        video_active = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        speed = 3'd0; pause = 1'b0; mode = 1'b0;
        cyc();
        cyc();
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_hs", 32'(hsync_out), 32'd0);
        chk("rst_off0", off0(), 32'd0);
        chk("rst_off1", 32'(dut.g_ch[1].u_ctr.off_q), 32'd50);
        chk("rst_off2", 32'(dut.g_ch[2].u_ctr.off_q), 32'd100);
        chk("rst_st0", st0(), 32'(UP));
        chk("rst_st2", 32'(dut.g_ch[2].u_ctr.state_q), 32'(UP));
        rst_n = 1'b1;

        // Two-cycle latency of colour and hsync
        video_active = 1'b1; pix_x = 10'd320; pix_y = 10'd240; hsync_in = 1'b1;
        cyc();
        chk("lat1_rgb", 32'(rgb_out), 32'd0);
        chk("lat1_hs", 32'(hsync_out), 32'd0);
        cyc();
        chk("lat2_rgb", 32'(rgb_out), 32'b000011);
        chk("lat2_hs", 32'(hsync_out), 32'd1);
        hsync_in = 1'b0;

        // First frame tick at speed 1
        speed = 3'd1; vsync_in = 1'b1;
        cyc();
        chk("tick_hi", 32'(frame_tick), 32'd1);
        chk("off0_pre", off0(), 32'd0);
        cyc();
        chk("tick_lo", 32'(frame_tick), 32'd0);
        chk("vs_out", 32'(vsync_out), 32'd1);
        chk("f1_off0", off0(), 32'd1);
        chk("f1_off1", 32'(dut.g_ch[1].u_ctr.off_q), 32'd51);
        chk("f1_off2", 32'(dut.g_ch[2].u_ctr.off_q), 32'd101);
        t0 = tick_cnt;
        repeat (100) cyc();
        chk("vs_hold_ticks", 32'(tick_cnt - t0), 32'd0);
        vsync_in = 1'b0;
        cyc();

        // Climb ch0 to the top
        speed = 3'd7;
        repeat (28) frame();
        chk("climb_off0", off0(), 32'd197);
        speed = 3'd1;
        frame();
        chk("off0_198", off0(), 32'd198);
        chk("st0_up", st0(), 32'(UP));
        speed = 3'd3;
        frame();
        chk("off0_max", off0(), 32'd200);
        chk("st0_down", st0(), 32'(DOWN));

        // ch0 (off 200) and ch1 both cover (160,122)
        pix_x = 10'd160; pix_y = 10'd122; mode = 1'b0;
        cyc(); cyc();
        chk("ovl_prio", 32'(rgb_out), 32'b000011);
        mode = 1'b1;
        cyc(); cyc();
`ifdef DEMO_BLEND_EN
        chk("ovl_mode1", 32'(rgb_out), 32'b001111);
`else
        chk("ovl_mode1", 32'(rgb_out), 32'b000011);
`endif
        mode = 1'b0;

        frame();
        chk("off0_197", off0(), 32'd197);
        speed = 3'd7;
        repeat (27) frame();
        chk("off0_8", off0(), 32'd8);
        speed = 3'd3;
        frame();
        frame();
        chk("off0_2", off0(), 32'd2);
        chk("st0_down2", st0(), 32'(DOWN));
        frame();
        chk("off0_0", off0(), 32'd0);
        chk("st0_up2", st0(), 32'(UP));
        chk("off1_44", 32'(dut.g_ch[1].u_ctr.off_q), 32'd44);
        chk("off2_93", 32'(dut.g_ch[2].u_ctr.off_q), 32'd93);

        // Edges of ch0 at off 0 (half sizes 20 x 20)
        pix_x = 10'd339; pix_y = 10'd240;
        cyc(); cyc();
        chk("edge_x_in", 32'(rgb_out), 32'b000011);
        pix_x = 10'd340;
        cyc(); cyc();
        chk("edge_x_out", 32'(rgb_out), 32'd0);
        pix_x = 10'd320; pix_y = 10'd259;
        cyc(); cyc();
        chk("edge_y_in", 32'(rgb_out), 32'b000011);
        pix_y = 10'd260;
        cyc(); cyc();
        chk("edge_y_out", 32'(rgb_out), 32'd0);
        pix_x = 10'd339; pix_y = 10'd240; video_active = 1'b0;
        cyc(); cyc();
        chk("blank", 32'(rgb_out), 32'd0);

        // Pause and zero speed hold offsets while ticks keep coming
        pause = 1'b1; speed = 3'd3;
        t0 = tick_cnt;
        repeat (5) frame();
        chk("pause_ticks", 32'(tick_cnt - t0), 32'd5);
        chk("pause_off0", off0(), 32'd0);
        chk("pause_off1", 32'(dut.g_ch[1].u_ctr.off_q), 32'd44);
        pause = 1'b0; speed = 3'd0;
        t0 = tick_cnt;
        repeat (5) frame();
        chk("s0_ticks", 32'(tick_cnt - t0), 32'd5);
        chk("s0_off0", off0(), 32'd0);
        chk("s0_off2", 32'(dut.g_ch[2].u_ctr.off_q), 32'd93);

        // Asynchronous reset mid-line
        speed = 3'd3; video_active = 1'b1; pix_x = 10'd320; pix_y = 10'd240; hsync_in = 1'b1;
        cyc(); cyc();
        chk("pre_rst_rgb", 32'(rgb_out), 32'b000011);
        vsync_in = 1'b1;
        cyc();
        chk("pre_rst_tick", 32'(frame_tick), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_rgb", 32'(rgb_out), 32'd0);
        chk("arst_hs", 32'(hsync_out), 32'd0);
        chk("arst_tick", 32'(frame_tick), 32'd0);
        chk("arst_off1", 32'(dut.g_ch[1].u_ctr.off_q), 32'd50);
        chk("arst_off2", 32'(dut.g_ch[2].u_ctr.off_q), 32'd100);
        rst_n = 1'b1;
        cyc();
        chk("rel_tick", 32'(frame_tick), 32'd1);
        cyc();
        chk("rel_off0", off0(), 32'd3);
        chk("rel_vs_out", 32'(vsync_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
